// File: rtl/lanzones_fetch_unit.sv
// Instruction-fetch front end: keeps up to DEPTH fetches in flight, buffers returned words with their PCs,
// and flushes on redirect while silently discarding responses to fetches issued before the redirect.
module lanzones_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            req_vld,
    input  logic            req_rdy,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_vld,
    input  logic [XLEN-1:0] rsp_data,
    output logic            rsp_rdy,
    output logic            inst_vld,
    input  logic            inst_rdy,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redir_en,
    input  logic [XLEN-1:0] redir_pc
);
    localparam int unsigned     IW         = $clog2(DEPTH);
    localparam int unsigned     PW         = IW + 1;
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));
    localparam logic [PW:0]     DEPTH_W    = (PW+1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [PW-1:0]    alloc_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    drop_cnt;
    logic [DEPTH-1:0] filled;
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];

    logic [PW-1:0] live;
    logic [PW-1:0] pending;
    logic [PW:0]   used;
    logic [IW-1:0] alloc_idx;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] rd_idx;
    logic          issue;
    logic          pop;
    logic          rsp_drop;
    logic          rsp_fill;
    logic          rsp_redir_sub;

    assign alloc_idx = alloc_ptr[IW-1:0];
    assign fill_idx  = fill_ptr[IW-1:0];
    assign rd_idx    = rd_ptr[IW-1:0];

    assign live    = alloc_ptr - rd_ptr;
    assign pending = alloc_ptr - fill_ptr;
    assign used    = {1'b0, live} + {1'b0, drop_cnt};

    assign req_vld  = rstn & ~redir_en & (used < DEPTH_W);
    assign req_addr = fetch_pc;
    assign rsp_rdy  = rstn;
    assign issue    = req_vld & req_rdy;

    // Stale responses are consumed first; a response with nothing outstanding is ignored.
    assign rsp_drop      = rsp_vld & (drop_cnt != '0);
    assign rsp_fill      = rsp_vld & (drop_cnt == '0) & (pending != '0);
    assign rsp_redir_sub = rsp_vld & ((drop_cnt != '0) | (pending != '0));

    assign inst_vld  = rstn & filled[rd_idx] & (live != '0);
    assign inst_data = inst_vld ? data_mem[rd_idx] : '0;
    assign inst_pc   = inst_vld ? pc_mem[rd_idx] : '0;
    assign pop       = inst_vld & inst_rdy & ~redir_en;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
        end else if (redir_en) begin
            // Everything outstanding becomes stale; the buffer empties by rewinding to the read pointer.
            fetch_pc  <= redir_pc & ALIGN_MASK;
            alloc_ptr <= rd_ptr;
            fill_ptr  <= rd_ptr;
            drop_cnt  <= drop_cnt + pending - PW'(rsp_redir_sub);
        end else begin
            if (issue) begin
                alloc_ptr         <= alloc_ptr + PW'(1);
                fetch_pc          <= fetch_pc + STEP;
                filled[alloc_idx] <= 1'b0;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (rsp_fill) begin
                filled[fill_idx] <= 1'b1;
                fill_ptr         <= fill_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_mem[alloc_idx] <= fetch_pc;
        end
        if (rsp_fill && !redir_en) begin
            data_mem[fill_idx] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_lanzones_fetch_unit.sv
// Bench for lanzones_fetch_unit: a transaction-level model of memory and of the instruction stream,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_lanzones_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rstn;
    logic        req_vld, req_rdy, rsp_vld, rsp_rdy, inst_vld, inst_rdy, redir_en;
    logic [31:0] req_addr, rsp_data, inst_data, inst_pc, redir_pc;

    logic        req_vld2, rsp_vld2, rsp_rdy2, inst_vld2;
    logic [31:0] req_addr2, rsp_data2, inst_data2, inst_pc2;
    logic        req_rdy2, inst_rdy2, redir_en2;
    logic [31:0] redir_pc2;

    logic        rsp_en;
    logic [31:0] memq[$];
    logic [31:0] wq[$];
    logic [31:0] pops[$];
    logic [31:0] accs[$];
    logic [31:0] wlog[$];

    int n_chk  = 0;
    int n_pass = 0;

    lanzones_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rstn(rstn),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
        .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_data(inst_data), .inst_pc(inst_pc),
        .redir_en(redir_en), .redir_pc(redir_pc)
    );

    lanzones_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rstn(rstn),
        .req_vld(req_vld2), .req_rdy(req_rdy2), .req_addr(req_addr2),
        .rsp_vld(rsp_vld2), .rsp_data(rsp_data2), .rsp_rdy(rsp_rdy2),
        .inst_vld(inst_vld2), .inst_rdy(inst_rdy2), .inst_data(inst_data2), .inst_pc(inst_pc2),
        .redir_en(redir_en2), .redir_pc(redir_pc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory for the main DUT: in-order responses, earliest the cycle after accept, gated by rsp_en.
    initial begin
        logic        m_acc, m_took, m_rst;
        logic [31:0] m_addr;
        rsp_vld  = 1'b0;
        rsp_data = '0;
        forever begin
            @(negedge clk);
            m_acc  = req_vld && req_rdy;
            m_addr = req_addr;
            m_took = rsp_vld && rsp_rdy;
            m_rst  = !rstn;
            @(posedge clk);
            #2;
            if (m_rst) memq.delete();
            else begin
                if (m_took) void'(memq.pop_front());
                if (m_acc) memq.push_back(m_addr);
            end
            rsp_vld  = rsp_en && (memq.size() != 0);
            rsp_data = rsp_vld ? word_of(memq[0]) : '0;
        end
    end

    // Free-running memory and consumer for the wrap instance.
    initial begin
        logic        w_acc, w_took, w_rst;
        logic [31:0] w_addr;
        req_rdy2 = 1'b1; inst_rdy2 = 1'b1; redir_en2 = 1'b0; redir_pc2 = '0;
        rsp_vld2 = 1'b0; rsp_data2 = '0;
        forever begin
            @(negedge clk);
            w_acc  = req_vld2 && req_rdy2;
            w_addr = req_addr2;
            w_took = rsp_vld2 && rsp_rdy2;
            w_rst  = !rstn;
            if (rstn && inst_vld2) begin
                chk("wrap_data", inst_data2, word_of(inst_pc2));
                if (wlog.size() < 3) wlog.push_back(inst_pc2);
            end
            @(posedge clk);
            #2;
            if (w_rst) wq.delete();
            else begin
                if (w_took) void'(wq.pop_front());
                if (w_acc) wq.push_back(w_addr);
            end
            rsp_vld2  = wq.size() != 0;
            rsp_data2 = rsp_vld2 ? word_of(wq[0]) : '0;
        end
    end

    // Transaction model: expected next instruction PC, expected next fetch address,
    // buffered-but-unconsumed words of the current stream, and stale responses still owed by memory.
    logic [31:0] exp_pc, exp_fetch;
    int          buf_cnt, stale;

    always @(negedge clk) begin
        logic took;
        logic [31:0] tgt;
        if (!rstn) begin
            chk("rst_req_vld", req_vld, 1'b0);
            chk("rst_rsp_rdy", rsp_rdy, 1'b0);
            chk("rst_inst_vld", inst_vld, 1'b0);
            chk("rst_inst_out", {inst_data, inst_pc}, 64'h0);
            exp_pc = 32'h0; exp_fetch = 32'h0; buf_cnt = 0; stale = 0;
        end else begin
            chk("rsp_rdy", rsp_rdy, 1'b1);
            chk("req_vld", req_vld, !redir_en && (memq.size() + buf_cnt < DEPTH));
            chk("inst_vld", inst_vld, buf_cnt > 0);
            if (inst_vld) chk("inst_data", inst_data, word_of(inst_pc));
            else chk("idle_out", {inst_data, inst_pc}, 64'h0);
            if (req_vld && req_rdy) begin
                chk("req_addr", req_addr, exp_fetch);
                accs.push_back(req_addr);
                exp_fetch = exp_fetch + 32'd4;
            end
            took = rsp_vld;
            if (redir_en) begin
                tgt       = redir_pc & ~32'h3;
                stale     = memq.size() - int'(took);
                buf_cnt   = 0;
                exp_pc    = tgt;
                exp_fetch = tgt;
            end else begin
                if (inst_vld && inst_rdy) begin
                    chk("inst_pc", inst_pc, exp_pc);
                    pops.push_back(inst_pc);
                    exp_pc  = exp_pc + 32'd4;
                    buf_cnt = buf_cnt - 1;
                end
                if (took) begin
                    if (stale > 0) stale = stale - 1;
                    else buf_cnt = buf_cnt + 1;
                end
            end
        end
    end

    task automatic do_reset(input logic rsp_on);
        rstn = 1'b0; req_rdy = 1'b0; inst_rdy = 1'b0; redir_en = 1'b0; redir_pc = '0; rsp_en = rsp_on;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; req_rdy = 1'b0; inst_rdy = 1'b0; redir_en = 1'b0; redir_pc = '0; rsp_en = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("t1_req_vld", req_vld, 1'b1);
        chk("t1_req_addr", req_addr, 32'h0);

        // Full-rate stream
        tick();
        pops.delete();
        req_rdy = 1'b1; inst_rdy = 1'b1;
        repeat (14) tick();
        chk("t2_count_ge8", pops.size() >= 8, 1'b1);
        chk("t2_pc0", q_at(pops, 0), 32'h0);
        chk("t2_pc1", q_at(pops, 1), 32'h4);
        chk("t2_pc3", q_at(pops, 3), 32'hC);
        chk("t6_wrap0", q_at(wlog, 0), 32'hFFFF_FFF8);
        chk("t6_wrap1", q_at(wlog, 1), 32'hFFFF_FFFC);
        chk("t6_wrap2", q_at(wlog, 2), 32'h0000_0000);

        // Backpressure: decode stalled, exactly DEPTH fetches accepted
        do_reset(1'b1);
        req_rdy = 1'b1;
        accs.delete(); pops.delete();
        repeat (10) tick();
        chk("t3_accepts", accs.size(), 4);
        chk("t3_first", q_at(accs, 0), 32'h0);
        chk("t3_last", q_at(accs, 3), 32'hC);
        chk("t3_full", req_vld, 1'b0);
        accs.delete();
        inst_rdy = 1'b1;
        tick();
        inst_rdy = 1'b0;
        repeat (4) tick();
        chk("t3_refill_cnt", accs.size(), 1);
        chk("t3_refill_addr", q_at(accs, 0), 32'h10);

        // Back-to-back redirects with a full buffer: the last target wins
        redir_en = 1'b1; redir_pc = 32'h300;
        tick();
        redir_pc = 32'h506;
        tick();
        redir_en = 1'b0; inst_rdy = 1'b1;
        pops.delete();
        repeat (8) tick();
        chk("t3b_pc0", q_at(pops, 0), 32'h504);
        chk("t3b_pc1", q_at(pops, 1), 32'h508);

        // Redirect with two fetches outstanding
        do_reset(1'b0);
        req_rdy = 1'b1;
        repeat (2) tick();
        req_rdy = 1'b0;
        redir_en = 1'b1; redir_pc = 32'h103;
        tick();
        redir_en = 1'b0; rsp_en = 1'b1; req_rdy = 1'b1; inst_rdy = 1'b1;
        pops.delete();
        repeat (12) tick();
        chk("t4_pc0", q_at(pops, 0), 32'h100);
        chk("t4_pc1", q_at(pops, 1), 32'h104);

        // Redirect in the same cycle as a response, one other fetch outstanding
        do_reset(1'b0);
        req_rdy = 1'b1;
        repeat (2) tick();
        req_rdy = 1'b0;
        redir_en = 1'b1; redir_pc = 32'h200; rsp_en = 1'b1;
        tick();
        redir_en = 1'b0; req_rdy = 1'b1; inst_rdy = 1'b1;
        pops.delete();
        repeat (12) tick();
        chk("t5_pc0", q_at(pops, 0), 32'h200);
        chk("t5_pc1", q_at(pops, 1), 32'h204);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
